// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with a 2-flop input synchronizer,
// mid-bit sampling, 7/8 data bits, optional odd/even parity and one or two
// stop bits. Frame configuration is captured at the start edge so that
// configuration changes during a frame have no effect on that frame.
module uart_rx #(
   // Bit period in clocks for each baud_rate code. The half period used to
   // reach the middle of the start bit is derived as period/2.
   parameter int unsigned PERIOD_B00 = 20834,
   parameter int unsigned PERIOD_B01 = 10418,
   parameter int unsigned PERIOD_B10 = 5210,
   parameter int unsigned PERIOD_B11 = 2606
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [1:0] baud_rate,
   input  logic       data_in,
   input  logic [1:0] parity_type,
   input  logic       stop_bits,
   input  logic       data_length,
   output logic [7:0] data_out,
   output logic       rx_active,
   output logic       rx_done,
   output logic       parity_error,
   output logic       frame_error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_t;

   localparam logic [15:0] PERIOD_00 = 16'(PERIOD_B00);
   localparam logic [15:0] PERIOD_01 = 16'(PERIOD_B01);
   localparam logic [15:0] PERIOD_10 = 16'(PERIOD_B10);
   localparam logic [15:0] PERIOD_11 = 16'(PERIOD_B11);

   // Input synchronizer and start-edge detection
   logic       sync1_q;
   logic       sync2_q;
   logic [1:0] flush_q;
   logic       line_prev_q;
   logic       rx_line;
   logic       fall_seen;

   // Frame sequencing state
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;

   // Configuration captured at the start edge
   logic [1:0]  baud_q, baud_d;
   logic [1:0]  ptype_q, ptype_d;
   logic        stop2_q, stop2_d;
   logic        len8_q, len8_d;

   // Errors collected while the frame is in flight
   logic        par_pend_q, par_pend_d;
   logic        frm_pend_q, frm_pend_d;

   // Registered results, updated together at frame completion
   logic [7:0]  data_out_q, data_out_d;
   logic        parity_error_q, parity_error_d;
   logic        frame_error_q, frame_error_d;
   logic        rx_done_q, rx_done_d;

   // Derived per-frame values
   logic [15:0] period;
   logic [15:0] period_m1;
   logic [15:0] half_m1;
   logic        bit_tick;
   logic        parity_on;
   logic [2:0]  last_bit;
   logic [7:0]  data_word;
   logic        frame_end;

   assign rx_line   = sync2_q;
   // line_prev_q only reports "high" once the synchronizer holds real line
   // data, so a line held low across reset never looks like a start edge.
   assign fall_seen = line_prev_q & ~rx_line;

   // Bring the asynchronous line into the clock domain and remember the
   // previous synchronized value for falling-edge detection.
   always_ff @(posedge clock) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         flush_q     <= 2'b00;
         line_prev_q <= 1'b0;
      end else begin
         sync1_q     <= data_in;
         sync2_q     <= sync1_q;
         flush_q     <= {flush_q[0], 1'b1};
         line_prev_q <= sync2_q & flush_q[1];
      end
   end

   // Select the bit period from the baud code latched for this frame.
   always_comb begin
      period = PERIOD_00;
      case (baud_q)
         2'b00:   period = PERIOD_00;
         2'b01:   period = PERIOD_01;
         2'b10:   period = PERIOD_10;
         default: period = PERIOD_11;
      endcase
   end

   assign period_m1 = period - 16'd1;
   assign half_m1   = (period >> 1) - 16'd1;
   assign bit_tick  = (cnt_q == period_m1);
   assign parity_on = (ptype_q == 2'b01) || (ptype_q == 2'b10);
   assign last_bit  = len8_q ? 3'd7 : 3'd6;
   assign data_word = len8_q ? shift_q : {1'b0, shift_q[6:0]};

   // Next-state logic: bit timing, sampling, error collection and the
   // single-cycle completion update.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bit_d          = bit_q;
      shift_d        = shift_q;
      baud_d         = baud_q;
      ptype_d        = ptype_q;
      stop2_d        = stop2_q;
      len8_d         = len8_q;
      par_pend_d     = par_pend_q;
      frm_pend_d     = frm_pend_q;
      data_out_d     = data_out_q;
      parity_error_d = parity_error_q;
      frame_error_d  = frame_error_q;
      rx_done_d      = 1'b0;
      frame_end      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = 16'd0;
            if (fall_seen) begin
               state_d    = START;
               bit_d      = 3'd0;
               shift_d    = 8'h00;
               par_pend_d = 1'b0;
               frm_pend_d = 1'b0;
               baud_d     = baud_rate;
               ptype_d    = parity_type;
               stop2_d    = stop_bits;
               len8_d     = data_length;
            end
         end

         START: begin
            if (cnt_q == half_m1) begin
               cnt_d = 16'd0;
               // A high line at mid-start means the fall was a glitch;
               // drop back without touching any result register.
               state_d = rx_line ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (bit_tick) begin
               cnt_d          = 16'd0;
               shift_d[bit_q] = rx_line;
               if (bit_q == last_bit) begin
                  bit_d   = 3'd0;
                  state_d = parity_on ? PARITY : STOP1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         PARITY: begin
            if (bit_tick) begin
               cnt_d = 16'd0;
               // XOR of data and parity bit is 1 for an odd count of ones;
               // odd parity expects 1, even parity expects 0.
               par_pend_d = (^data_word) ^ rx_line ^ (ptype_q == 2'b01);
               state_d    = STOP1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         STOP1: begin
            if (bit_tick) begin
               cnt_d      = 16'd0;
               frm_pend_d = frm_pend_q | ~rx_line;
               if (stop2_q) begin
                  state_d = STOP2;
               end else begin
                  frame_end = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         STOP2: begin
            if (bit_tick) begin
               cnt_d      = 16'd0;
               frm_pend_d = frm_pend_q | ~rx_line;
               frame_end  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      if (frame_end) begin
         state_d        = IDLE;
         rx_done_d      = 1'b1;
         data_out_d     = data_word;
         parity_error_d = par_pend_q;
         frame_error_d  = frm_pend_d;
      end
   end

   // Register all frame state and results.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= 16'd0;
         bit_q          <= 3'd0;
         shift_q        <= 8'h00;
         baud_q         <= 2'b00;
         ptype_q        <= 2'b00;
         stop2_q        <= 1'b0;
         len8_q         <= 1'b0;
         par_pend_q     <= 1'b0;
         frm_pend_q     <= 1'b0;
         data_out_q     <= 8'h00;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         rx_done_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bit_q          <= bit_d;
         shift_q        <= shift_d;
         baud_q         <= baud_d;
         ptype_q        <= ptype_d;
         stop2_q        <= stop2_d;
         len8_q         <= len8_d;
         par_pend_q     <= par_pend_d;
         frm_pend_q     <= frm_pend_d;
         data_out_q     <= data_out_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         rx_done_q      <= rx_done_d;
      end
   end

   assign data_out     = data_out_q;
   assign rx_active    = (state_q != IDLE);
   assign rx_done      = rx_done_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into two receivers (one with shortened
// bit periods, one with the production periods) and compares every
// completed frame with an arithmetic model of the frame rules.
module tb_uart_rx;

   localparam int TR = 2606;   // production period for baud code 11

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Shortened-period instance
   logic       rst_s, din_s, stop_s, len_s;
   logic [1:0] baud_s, ptype_s;
   logic [7:0] data_out_s;
   logic       rx_active_s, rx_done_s, parity_error_s, frame_error_s;

   // Production-period instance
   logic       rst_r, din_r, stop_r, len_r;
   logic [1:0] baud_r, ptype_r;
   logic [7:0] data_out_r;
   logic       rx_active_r, rx_done_r, parity_error_r, frame_error_r;

   uart_rx #(
      .PERIOD_B00(48), .PERIOD_B01(32), .PERIOD_B10(24), .PERIOD_B11(16)
   ) dut_s (
      .clock(clk), .rst(rst_s), .baud_rate(baud_s), .data_in(din_s),
      .parity_type(ptype_s), .stop_bits(stop_s), .data_length(len_s),
      .data_out(data_out_s), .rx_active(rx_active_s), .rx_done(rx_done_s),
      .parity_error(parity_error_s), .frame_error(frame_error_s)
   );

   uart_rx dut_r (
      .clock(clk), .rst(rst_r), .baud_rate(baud_r), .data_in(din_r),
      .parity_type(ptype_r), .stop_bits(stop_r), .data_length(len_r),
      .data_out(data_out_r), .rx_active(rx_active_r), .rx_done(rx_done_r),
      .parity_error(parity_error_r), .frame_error(frame_error_r)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      int unsigned c;
      logic [7:0]  d;
      logic        pe;
      logic        fe;
   } done_t;

   done_t q_s[$];

   // Record every completion pulse of the shortened instance.
   always @(posedge clk) begin : mon_s
      done_t e;
      #1;
      if (rx_done_s !== 1'b0) begin
         e.c  = cyc;
         e.d  = data_out_s;
         e.pe = parity_error_s;
         e.fe = frame_error_s;
         q_s.push_back(e);
      end
   end

   int unsigned done_cnt_r = 0, done_cyc_r = 0, act_cnt_r = 0;
   logic [7:0]  done_d_r = 8'h00;
   logic        done_pe_r = 1'b0, done_fe_r = 1'b0;

   always @(posedge clk) begin : mon_r
      #1;
      if (rx_active_r === 1'b1) act_cnt_r = act_cnt_r + 1;
      if (rx_done_r !== 1'b0) begin
         done_cnt_r = done_cnt_r + 1;
         done_cyc_r = cyc;
         done_d_r   = data_out_r;
         done_pe_r  = parity_error_r;
         done_fe_r  = frame_error_r;
      end
   end

   logic [7:0] last_d;
   logic       last_pe, last_fe;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   function automatic int tper(input logic [1:0] b);
      case (b)
         2'b00:   return 48;
         2'b01:   return 32;
         2'b10:   return 24;
         default: return 16;
      endcase
   endfunction

   // Expected cycle of the rx_done pulse: two synchronizer stages, one edge
   // to detect the fall, half a bit to mid-start, then one period per bit.
   function automatic int unsigned exp_done(input int unsigned fall, input logic [1:0] b,
                                            input logic [1:0] p, input logic s2, input logic l8);
      int t;
      int na;
      t  = tper(b);
      na = (l8 ? 8 : 7) + ((p == 2'b01 || p == 2'b10) ? 1 : 0) + 1 + (s2 ? 1 : 0);
      return fall + 3 + t / 2 + na * t;
   endfunction

   // Frame rules as arithmetic: masked data, ones count for parity, any low stop bit.
   function automatic void model(input logic [7:0] d, input logic l8, input logic [1:0] p,
                                 input logic pb, input logic s2, input logic [1:0] sv,
                                 output logic [7:0] ed, output logic epe, output logic efe);
      int ones;
      ed   = l8 ? d : (d & 8'h7F);
      ones = $countones(ed) + (pb ? 1 : 0);
      if (p == 2'b01)      epe = (ones % 2 == 0);
      else if (p == 2'b10) epe = (ones % 2 == 1);
      else                 epe = 1'b0;
      efe = !sv[0] || (s2 && !sv[1]);
   endfunction

   // Send one frame on the shortened instance. The line is left high on return
   // with no extra idle time, so consecutive calls are back-to-back.
   task automatic send_s(input logic [1:0] b, input logic [1:0] p, input logic s2, input logic l8,
                         input logic [7:0] d, input logic pb, input logic [1:0] sv,
                         output int unsigned fall);
      int t;
      t       = tper(b);
      baud_s  = b;
      ptype_s = p;
      stop_s  = s2;
      len_s   = l8;
      din_s   = 1'b0;
      fall    = cyc;
      tick(t);
      // Configuration changes after the start edge must not affect the frame.
      baud_s  = 2'($urandom);
      ptype_s = 2'($urandom);
      stop_s  = 1'($urandom);
      len_s   = 1'($urandom);
      for (int i = 0; i < (l8 ? 8 : 7); i++) begin
         din_s = d[i];
         tick(t);
      end
      if (p == 2'b01 || p == 2'b10) begin
         din_s = pb;
         tick(t);
      end
      din_s = sv[0];
      tick(t);
      if (s2) begin
         din_s = sv[1];
         tick(t);
      end
      din_s = 1'b1;
   endtask

   task automatic expect_one(input string tag, input int unsigned ecyc, input logic [7:0] ed,
                             input logic epe, input logic efe);
      check({tag, "_pulses"}, q_s.size(), 1);
      if (q_s.size() > 0) begin
         done_t e;
         e = q_s.pop_front();
         check({tag, "_latency"}, e.c, ecyc);
         check({tag, "_data"}, e.d, ed);
         check({tag, "_parity_error"}, e.pe, epe);
         check({tag, "_frame_error"}, e.fe, efe);
      end
      q_s.delete();
      last_d  = ed;
      last_pe = epe;
      last_fe = efe;
   endtask

   typedef struct {
      logic [1:0] baud;
      logic [1:0] ptype;
      logic       stop2;
      logic       len8;
      logic [7:0] data;
      logic       pbit;
      logic [1:0] stopv;
      logic [7:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   vec_t vecs[9];

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: time limit reached at cycle %0d, expected completion earlier", cyc);
      $fatal(1, "time limit");
   end

   initial begin : main
      //            baud   ptype  s2    l8    data   pbit  stopv  exp_d  pe    fe
      vecs[0] = '{2'b10, 2'b01, 1'b0, 1'b1, 8'h99, 1'b1, 2'b11, 8'h99, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 2'b01, 1'b0, 1'b1, 8'h99, 1'b0, 2'b11, 8'h99, 1'b1, 1'b0};
      vecs[2] = '{2'b11, 2'b10, 1'b1, 1'b0, 8'h55, 1'b0, 2'b01, 8'h55, 1'b0, 1'b1};
      vecs[3] = '{2'b00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{2'b01, 2'b01, 1'b0, 1'b0, 8'h7F, 1'b0, 2'b11, 8'h7F, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 2'b10, 1'b0, 1'b1, 8'hFF, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{2'b01, 2'b11, 1'b1, 1'b1, 8'hA5, 1'b1, 2'b10, 8'hA5, 1'b0, 1'b1};
      vecs[7] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'hF0, 1'b0, 2'b11, 8'h70, 1'b0, 1'b0};
      vecs[8] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0};

      rst_s = 1'b1; rst_r = 1'b1; din_s = 1'b1; din_r = 1'b1;
      baud_s = 2'b00; ptype_s = 2'b00; stop_s = 1'b0; len_s = 1'b1;
      baud_r = 2'b11; ptype_r = 2'b00; stop_r = 1'b0; len_r = 1'b1;
      last_d = 8'h00; last_pe = 1'b0; last_fe = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_s = 1'b0;
      rst_r = 1'b0;

      check("reset_data_out", data_out_s, 8'h00);
      check("reset_rx_active", rx_active_s, 1'b0);
      check("reset_rx_done", rx_done_s, 1'b0);
      check("reset_parity_error", parity_error_s, 1'b0);
      check("reset_frame_error", frame_error_s, 1'b0);
      check("reset_real_data_out", data_out_r, 8'h00);

      fork
         begin : shortened
            int unsigned f1, f2;
            tick(4);

            foreach (vecs[i]) begin
               send_s(vecs[i].baud, vecs[i].ptype, vecs[i].stop2, vecs[i].len8, vecs[i].data,
                      vecs[i].pbit, vecs[i].stopv, f1);
               expect_one($sformatf("vec%0d", i),
                          exp_done(f1, vecs[i].baud, vecs[i].ptype, vecs[i].stop2, vecs[i].len8),
                          vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
               tick(3);
            end

            // 7E2 with a low second stop bit, then the line stuck low for 5T.
            send_s(2'b11, 2'b10, 1'b1, 1'b0, 8'h55, 1'b0, 2'b01, f1);
            expect_one("stuck_frame", exp_done(f1, 2'b11, 2'b10, 1'b1, 1'b0), 8'h55, 1'b0, 1'b1);
            din_s = 1'b0;
            tick(5 * 16);
            check("stuck_low_no_retrigger", q_s.size(), 0);
            check("stuck_low_idle", rx_active_s, 1'b0);
            din_s = 1'b1;
            tick(3);

            // Glitch: low for a quarter bit at baud 00 (T=48, H=24).
            baud_s = 2'b00; ptype_s = 2'b00; stop_s = 1'b0; len_s = 1'b1;
            din_s = 1'b0;
            tick(12);
            din_s = 1'b1;
            tick(96);
            check("glitch_no_pulse", q_s.size(), 0);
            check("glitch_data_held", data_out_s, last_d);
            check("glitch_pe_held", parity_error_s, last_pe);
            check("glitch_fe_held", frame_error_s, last_fe);
            check("glitch_idle", rx_active_s, 1'b0);

            // Back-to-back 8N1 frames.
            send_s(2'b00, 2'b00, 1'b0, 1'b1, 8'h01, 1'b0, 2'b11, f1);
            send_s(2'b00, 2'b00, 1'b0, 1'b1, 8'hFE, 1'b0, 2'b11, f2);
            check("b2b_pulses", q_s.size(), 2);
            if (q_s.size() == 2) begin
               done_t a, b;
               int unsigned gap;
               a = q_s.pop_front();
               b = q_s.pop_front();
               check("b2b_first_data", a.d, 8'h01);
               check("b2b_second_data", b.d, 8'hFE);
               check("b2b_first_latency", a.c, exp_done(f1, 2'b00, 2'b00, 1'b0, 1'b1));
               check("b2b_second_latency", b.c, exp_done(f2, 2'b00, 2'b00, 1'b0, 1'b1));
               gap = b.c - a.c;
               check("b2b_spacing_within_10T_pm1", (gap + 1 >= 480 && gap <= 481), 1'b1);
            end
            q_s.delete();
            last_d = 8'hFE; last_pe = 1'b0; last_fe = 1'b0;
            tick(3);

            // Reset during DATA, line held low across reset, then a clean frame.
            baud_s = 2'b01; ptype_s = 2'b00; stop_s = 1'b0; len_s = 1'b1;
            din_s = 1'b0;
            tick(32);
            din_s = 1'b1;
            tick(32);
            din_s = 1'b0;
            tick(16);
            check("rst_mid_active_before", rx_active_s, 1'b1);
            rst_s = 1'b1;
            tick(2);
            rst_s = 1'b0;
            check("rst_mid_active_after", rx_active_s, 1'b0);
            check("rst_mid_data_cleared", data_out_s, 8'h00);
            tick(40);
            check("rst_mid_no_pulse", q_s.size(), 0);
            check("rst_low_line_no_start", rx_active_s, 1'b0);
            din_s = 1'b1;
            tick(64);
            send_s(2'b01, 2'b00, 1'b0, 1'b1, 8'h3C, 1'b0, 2'b11, f1);
            expect_one("after_rst", exp_done(f1, 2'b01, 2'b00, 1'b0, 1'b1), 8'h3C, 1'b0, 1'b0);
            tick(3);

            // Randomised frames against the model.
            for (int k = 0; k < 40; k++) begin
               logic [1:0] b, p, sv;
               logic       s2, l8, pb, epe, efe;
               logic [7:0] d, ed;
               int         gap;
               b     = 2'($urandom_range(0, 3));
               p     = 2'($urandom_range(0, 3));
               s2    = 1'($urandom);
               l8    = 1'($urandom);
               pb    = 1'($urandom);
               d     = 8'($urandom);
               sv[0] = ($urandom_range(0, 4) != 0);
               sv[1] = ($urandom_range(0, 4) != 0);
               model(d, l8, p, pb, s2, sv, ed, epe, efe);
               send_s(b, p, s2, l8, d, pb, sv, f1);
               expect_one($sformatf("rnd%0d", k), exp_done(f1, b, p, s2, l8), ed, epe, efe);
               gap = $urandom_range(0, 3);
               if (efe && gap < 2) gap = 2;
               tick(gap);
            end
         end

         begin : production
            int unsigned fr;
            logic [7:0]  byte_a5;
            byte_a5 = 8'hA5;
            tick(4);
            act_cnt_r = 0;
            fr = cyc;
            din_r = 1'b0;
            tick(TR);
            for (int i = 0; i < 8; i++) begin
               din_r = byte_a5[i];
               tick(TR);
            end
            din_r = 1'b1;
            tick(TR);
            tick(10);
            check("real_pulses", done_cnt_r, 1);
            check("real_latency", done_cyc_r, fr + 3 + TR / 2 + 9 * TR);
            check("real_data", done_d_r, 8'hA5);
            check("real_parity_error", done_pe_r, 1'b0);
            check("real_frame_error", done_fe_r, 1'b0);
            check("real_active_cycles", act_cnt_r, TR / 2 + 9 * TR);
         end
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
